// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the uart_tx requester arbiter.
package uart_tx_arb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned GID_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_RISE = 2'd2,
    ST_WAIT_FALL = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping upward.
module rr_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [GID_W-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Outer loop walks the search order from ptr; inner loop matches the index without variable selects.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (i == (32'(ptr) + k) % N_REQ)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = i[GID_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ byte producers.
// Optional packet lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned BUSY_GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [GID_W-1:0]        grant_id,
  output logic [15:0]             byte_cnt
);

  localparam int unsigned GW = (BUSY_GUARD > 1) ? $clog2(BUSY_GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(BUSY_GUARD - 1);

  arb_state_t        state, state_nxt;
  logic [GID_W-1:0]  ptr, ptr_adv, win_idx;
  logic [N_REQ-1:0]  arb_req, win_onehot;
  logic [BYTE_W-1:0] win_data;
  logic [GW-1:0]     guard_cnt;
  logic              accept, byte_done;

`ifdef UART_TX_ARB_LOCK_EN
  logic             locked;
  logic [GID_W-1:0] lock_id;
  logic             win_last;

  always_comb begin
    arb_req = req_valid;
    if (locked) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        arb_req[i] = req_valid[i] && (32'(lock_id) == i);
      end
    end
  end

  always_comb begin
    win_last = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(win_idx) == i) win_last = req_last[i];
    end
  end
`else
  logic req_last_unused;
  assign req_last_unused = ^req_last;
  assign arb_req         = req_valid;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req      (arb_req),
    .ptr      (ptr),
    .grant    (win_onehot),
    .grant_idx(win_idx)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(win_idx) == i) win_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign ptr_adv   = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + GID_W'(1);
  assign accept    = (state == ST_IDLE) && !tx_busy && (|arb_req);
  assign req_ready = accept ? win_onehot : '0;
  // A guard timeout still counts the byte as sent.
  assign byte_done = !tx_busy &&
                     (((state == ST_WAIT_RISE) && (guard_cnt == GUARD_LAST)) ||
                      (state == ST_WAIT_FALL));

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    case (state)
      ST_IDLE:      if (accept) state_nxt = ST_START;
      ST_START: begin
        tx_start  = 1'b1;
        state_nxt = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (tx_busy)                        state_nxt = ST_WAIT_FALL;
        else if (guard_cnt == GUARD_LAST)   state_nxt = ST_IDLE;
      end
      ST_WAIT_FALL: if (!tx_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      tx_data   <= '0;
      grant_id  <= '0;
      byte_cnt  <= '0;
      guard_cnt <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      locked    <= 1'b0;
      lock_id   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_data  <= win_data;
        grant_id <= win_idx;
`ifdef UART_TX_ARB_LOCK_EN
        if (win_last) begin
          ptr    <= ptr_adv;
          locked <= 1'b0;
        end else begin
          locked  <= 1'b1;
          lock_id <= win_idx;
        end
`else
        ptr <= ptr_adv;
`endif
      end
      if (state == ST_START)          guard_cnt <= '0;
      else if (state == ST_WAIT_RISE) guard_cnt <= guard_cnt + GW'(1);
      if (byte_done) byte_cnt <= byte_cnt + 16'd1;
    end
  end

endmodule
